// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane alignment, byte enables, load extension and
// splitting of word-crossing accesses into two memory accesses.
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_A0, S_A1, S_D, S_R} state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_w0;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic [3:0]  r_mem_we;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] o);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << o;
  endfunction

  function automatic logic [31:0] load_result(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [63:0] d64);
    logic [63:0] s;
    s = d64 >> {o, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return s[31:0];
    endcase
  endfunction

  // In IDLE the lane math works on the incoming request so word 0 can be
  // registered on the accept edge; afterwards it works on the latched copy.
  logic [2:0]  w_sel_funct3;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [7:0]  w_mask8;
  logic [63:0] w_data64;
  logic [2:0]  w_n;
  logic        w_split;
  logic [63:0] w_rd64;

  assign w_sel_funct3 = (r_state == S_IDLE) ? bus.req_funct3 : r_funct3;
  assign w_sel_addr   = (r_state == S_IDLE) ? bus.req_addr   : r_addr;
  assign w_sel_wdata  = (r_state == S_IDLE) ? bus.req_wdata  : r_wdata;
  assign w_mask8      = lane_mask(w_sel_funct3[1:0], w_sel_addr[1:0]);
  assign w_data64     = {32'b0, w_sel_wdata} << {w_sel_addr[1:0], 3'b000};
  assign w_n          = size_of(w_sel_funct3[1:0]);
  assign w_split      = ({1'b0, w_sel_addr[1:0]} + w_n) > 3'd4;
  assign w_rd64       = w_split ? {bus.mem_dout, r_w0} : {32'b0, bus.mem_dout};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b0;
      r_addr       <= 32'b0;
      r_wdata      <= 32'b0;
      r_w0         <= 32'b0;
      r_mem_addr   <= 32'b0;
      r_mem_din    <= 32'b0;
      r_mem_we     <= 4'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            if (is_legal(bus.req_we, bus.req_funct3)) begin
              r_state    <= S_A0;
              r_mem_addr <= {bus.req_addr[31:2], 2'b00};
              r_mem_din  <= w_data64[31:0];
              r_mem_we   <= bus.req_we ? w_mask8[3:0] : 4'b0;
            end else begin
              r_state      <= S_R;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'b0;
            end
          end
        end
        S_A0: begin
          if (w_split) begin
            r_state    <= S_A1;
            r_mem_addr <= {r_addr[31:2] + 30'd1, 2'b00};
            r_mem_din  <= w_data64[63:32];
            r_mem_we   <= r_we ? w_mask8[7:4] : 4'b0;
          end else begin
            r_state  <= S_D;
            r_mem_we <= 4'b0;
          end
        end
        S_A1: begin
          r_w0     <= bus.mem_dout;
          r_mem_we <= 4'b0;
          r_state  <= S_D;
        end
        S_D: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_we ? 32'b0 : load_result(r_funct3, r_addr[1:0], w_rd64);
          r_state      <= S_R;
        end
        S_R: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE) && !rst;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;
  assign bus.mem_we     = r_mem_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-enabled, read-before-write
// 1024x32 memory model attached to the memory port.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    bus.mem_dout <= mem[bus.mem_addr[11:2]];
    for (int i = 0; i < 4; i++)
      if (bus.mem_we[i]) mem[bus.mem_addr[11:2]][8*i +: 8] <= bus.mem_din[8*i +: 8];
  end

  int checks = 0;
  int passes = 0;

  logic [3:0]  log_we   [1:8];
  logic [31:0] log_addr [1:8];
  logic [31:0] log_din  [1:8];
  int          lat;
  int          we_cycles;
  logic [31:0] got_rdata;
  logic        got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request from a negedge, log memory-port activity per cycle
  // (index c = cycles after the accept edge) until resp_valid or timeout.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input string tag);
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      log_we[c] = 4'b0; log_addr[c] = 32'b0; log_din[c] = 32'b0;
    end
    lat = 0; we_cycles = 0; got_rdata = 32'hx; got_err = 1'bx;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      log_we[c]   = bus.mem_we;
      log_addr[c] = bus.mem_addr;
      log_din[c]  = bus.mem_din;
      if (bus.mem_we != 4'b0) we_cycles++;
      if (bus.resp_valid) begin
        lat = c; got_rdata = bus.resp_rdata; got_err = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    chk({tag, ".pulse"}, {31'b0, bus.resp_valid}, 32'd0);
    $display("txn %s we=%0b f3=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0b we_cycles=%0d",
             tag, we, f3, addr, wdata, lat, got_rdata, got_err, we_cycles);
  endtask

  initial begin
    logic rv_seen;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr   = 32'b0;
    bus.req_wdata  = 32'b0;

    repeat (3) @(negedge clk);
    chk("rst.ready",  {31'b0, bus.req_ready}, 32'd0);
    chk("rst.we",     {28'b0, bus.mem_we}, 32'd0);
    chk("rst.addr",   bus.mem_addr, 32'd0);
    chk("rst.din",    bus.mem_din, 32'd0);
    chk("rst.rvalid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst.rdata",  bus.resp_rdata, 32'd0);
    chk("rst.err",    {31'b0, bus.resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", {31'b0, bus.req_ready}, 32'd1);

    run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
    chk("sw10.lat",  lat, 3);
    chk("sw10.we",   {28'b0, log_we[1]}, 32'hF);
    chk("sw10.wecy", we_cycles, 1);
    chk("sw10.addr", log_addr[1], 32'h10);
    chk("sw10.din",  log_din[1], 32'hDEADBEEF);
    chk("sw10.rd",   got_rdata, 32'h0);

    run(1'b0, 3'b010, 32'h10, 32'h0, "lw10");
    chk("lw10.lat",  lat, 3);
    chk("lw10.rd",   got_rdata, 32'hDEADBEEF);
    chk("lw10.wecy", we_cycles, 0);
    chk("lw10.err",  {31'b0, got_err}, 32'd0);

    run(1'b1, 3'b000, 32'h13, 32'h80, "sb13");
    chk("sb13.we",  {28'b0, log_we[1]}, 32'h8);
    chk("sb13.din", {24'b0, log_din[1][31:24]}, 32'h80);
    run(1'b0, 3'b000, 32'h13, 32'h0, "lb13");
    chk("lb13.rd", got_rdata, 32'hFFFFFF80);
    run(1'b0, 3'b100, 32'h13, 32'h0, "lbu13");
    chk("lbu13.rd", got_rdata, 32'h00000080);

    run(1'b1, 3'b010, 32'h22, 32'h11223344, "sw22");
    chk("sw22.lat",   lat, 4);
    chk("sw22.a0adr", log_addr[1], 32'h20);
    chk("sw22.a0we",  {28'b0, log_we[1]}, 32'hC);
    chk("sw22.a0din", {16'b0, log_din[1][31:16]}, 32'h3344);
    chk("sw22.a1adr", log_addr[2], 32'h24);
    chk("sw22.a1we",  {28'b0, log_we[2]}, 32'h3);
    chk("sw22.a1din", {16'b0, log_din[2][15:0]}, 32'h1122);
    chk("sw22.wecy",  we_cycles, 2);
    run(1'b0, 3'b010, 32'h22, 32'h0, "lw22");
    chk("lw22.lat", lat, 4);
    chk("lw22.rd",  got_rdata, 32'h11223344);

    run(1'b1, 3'b010, 32'h0, 32'hAB000000, "sw0");
    run(1'b1, 3'b010, 32'h4, 32'h000000CD, "sw4");
    run(1'b0, 3'b001, 32'h3, 32'h0, "lh3");
    chk("lh3.lat", lat, 4);
    chk("lh3.rd",  got_rdata, 32'hFFFFCDAB);
    run(1'b0, 3'b101, 32'h3, 32'h0, "lhu3");
    chk("lhu3.rd", got_rdata, 32'h0000CDAB);

    run(1'b0, 3'b011, 32'h40, 32'h0, "ld011");
    chk("ld011.lat",  lat, 1);
    chk("ld011.err",  {31'b0, got_err}, 32'd1);
    chk("ld011.rd",   got_rdata, 32'h0);
    chk("ld011.wecy", we_cycles, 0);
    run(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, "st100");
    chk("st100.lat",  lat, 1);
    chk("st100.err",  {31'b0, got_err}, 32'd1);
    chk("st100.rd",   got_rdata, 32'h0);
    chk("st100.wecy", we_cycles, 0);

    // Split store at 0x3E, reset asserted while word 1 is on the bus.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h3E;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmid.a0we", {28'b0, bus.mem_we}, 32'hC);
    @(negedge clk);
    chk("rmid.a1we", {28'b0, bus.mem_we}, 32'h3);
    chk("rmid.a1adr", bus.mem_addr, 32'h40);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid.we0", {28'b0, bus.mem_we}, 32'd0);
    chk("rmid.rv0", {31'b0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    rv_seen = 1'b0;
    @(negedge clk);
    chk("rmid.ready", {31'b0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid) rv_seen = 1'b1;
      @(negedge clk);
    end
    chk("rmid.norv", {31'b0, rv_seen}, 32'd0);
    $display("txn rmid sw addr=0000003e reset during A1");
    run(1'b0, 3'b101, 32'h3E, 32'h0, "lhu3e");
    chk("lhu3e.rd", got_rdata, 32'h0000F00D);

    run(1'b1, 3'b001, 32'hFFFFFFFF, 32'h00001234, "shff");
    chk("shff.lat",   lat, 4);
    chk("shff.a0adr", log_addr[1], 32'hFFFFFFFC);
    chk("shff.a0we",  {28'b0, log_we[1]}, 32'h8);
    chk("shff.a1adr", log_addr[2], 32'h00000000);
    chk("shff.a1we",  {28'b0, log_we[2]}, 32'h1);
    run(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, "lhff");
    chk("lhff.rd", got_rdata, 32'h00001234);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
